frmbuf_wr: RTL and testbench

DDR3 frame-buffer writer. Drains a first-word-fall-through (FWFT) source FIFO into DDR3 through the MIG native app/wdf interface, one burst of P_WR_NUM 256-bit beats at a time. Each burst is granted by the shared DDR3 arbiter, and a source-vsync falling edge restarts the frame at i_addr_inital. It is the write-side peer of the frame-buffer reader and uses the same arbiter handshake and address scheme.

---
 rtl/frmbuf_wr.sv | 188 ++++++++++++++++++
 tb/tb_frmbuf_wr.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frmbuf_wr.sv
// frmbuf_wr: DDR3 frame-buffer writer.
// Drains a first-word-fall-through source FIFO into the MIG native app/wdf
// interface one burst of P_WR_NUM beats at a time. Each burst is granted by the
// shared DDR3 arbiter. A falling edge on the source vsync restarts the frame
// at i_addr_inital and flushes the source FIFO.
// Optional build macro FRMBUF_WR_STAT_EN adds o_beat_cnt and o_underflow.
module frmbuf_wr #(
  parameter int P_WR_NUM   = 32,
  parameter int P_ADDR_ADD = 8,
  parameter int P_DATA_W   = 256
) (
  input  logic                    i_ddr3_clk,
  input  logic                    i_rst_n,
  input  logic                    i_system_init,
  input  logic                    i_src_vsync,
  output logic                    o_fifo_rst,
  input  logic [9:0]              i_fifo_rd_cnt,
  input  logic                    i_fifo_empty,
  input  logic [P_DATA_W-1:0]     i_fifo_data,
  output logic                    o_fifo_rd,
  output logic                    o_request,
  input  logic                    i_response,
  output logic                    o_app_en,
  output logic [2:0]              o_app_cmd,
  output logic [26:0]             o_addr,
  input  logic                    i_app_rdy,
  output logic [P_DATA_W-1:0]     o_app_wdf_data,
  output logic                    o_app_wdf_wren,
  output logic                    o_app_wdf_end,
  output logic [P_DATA_W/8-1:0]   o_app_wdf_mask,
  input  logic                    i_app_wdf_rdy,
  input  logic [26:0]             i_addr_inital,
  output logic                    o_bust_end,
  output logic                    o_wr_busy,
`ifdef FRMBUF_WR_STAT_EN
  output logic [31:0]             o_beat_cnt,
  output logic                    o_underflow,
`endif
  output logic [2:0]              o_cs,
  output logic [2:0]              o_ns
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUF = 3'd1,
    S_ARB_REQ  = 3'd2,
    S_DATA_WR  = 3'd3,
    S_WR_EOP   = 3'd4
  } state_t;

  localparam logic [9:0]  WR_NUM    = 10'(P_WR_NUM);
  localparam logic [10:0] WR_NUM_X  = 11'(P_WR_NUM);
  localparam logic [26:0] ADDR_STEP = 27'(P_ADDR_ADD);

  logic [9:0]  vs_shift_q, vs_shift_d;
  logic        sync_pos_q, sync_pos_d;
  state_t      cs_q, ns;
  logic        request_q, request_d;
  logic        bust_end_q, bust_end_d;
  logic        app_en_q, app_en_d;
  logic        wren_q, wren_d;
  logic [9:0]  cmd_cnt_q, cmd_cnt_d;
  logic [9:0]  dat_cnt_q, dat_cnt_d;
  logic [26:0] addr_q, addr_d;
  logic        dat_acc, cmd_acc;
  logic [10:0] dat_next, cmd_next;

  assign dat_acc = wren_q && i_app_wdf_rdy;
  assign cmd_acc = app_en_q && i_app_rdy;

  // Next-state decode; a frame-start pulse pulls every state back to idle.
  always_comb begin
    ns = S_IDLE;
    case (cs_q)
      S_IDLE:     ns = i_system_init ? S_WAIT_BUF : S_IDLE;
      S_WAIT_BUF: ns = (i_fifo_rd_cnt >= WR_NUM) ? S_ARB_REQ : S_WAIT_BUF;
      S_ARB_REQ:  ns = i_response ? S_DATA_WR : S_ARB_REQ;
      S_DATA_WR:  ns = ((cmd_cnt_q == WR_NUM) && (dat_cnt_q == WR_NUM)) ? S_WR_EOP : S_DATA_WR;
      S_WR_EOP:   ns = S_IDLE;
      default:    ns = S_IDLE;
    endcase
    if (sync_pos_q) begin
      ns = S_IDLE;
    end
  end

  // Datapath next values: vsync edge detect, beat counters, enables, address.
  always_comb begin
    vs_shift_d = {vs_shift_q[8:0], i_src_vsync};
    sync_pos_d = (vs_shift_q[9:8] == 2'b10);
    dat_next   = {1'b0, dat_cnt_q} + {10'd0, dat_acc};
    cmd_next   = {1'b0, cmd_cnt_q} + {10'd0, cmd_acc};
    dat_cnt_d  = (ns == S_DATA_WR) ? dat_next[9:0] : 10'd0;
    cmd_cnt_d  = (ns == S_DATA_WR) ? cmd_next[9:0] : 10'd0;
    wren_d     = (ns == S_DATA_WR) && (dat_next < WR_NUM_X);
    app_en_d   = (ns == S_DATA_WR) && (cmd_next < WR_NUM_X) && (cmd_next < dat_next);
    request_d  = (ns == S_ARB_REQ);
    bust_end_d = (ns == S_WR_EOP);
    addr_d     = addr_q;
    if (sync_pos_q) begin
      addr_d = i_addr_inital;
    end else if (cmd_acc) begin
      addr_d = addr_q + ADDR_STEP;
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_shift_q <= '0;
      sync_pos_q <= 1'b0;
      cs_q       <= S_IDLE;
      request_q  <= 1'b0;
      bust_end_q <= 1'b0;
      app_en_q   <= 1'b0;
      wren_q     <= 1'b0;
      cmd_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      addr_q     <= '0;
    end else begin
      vs_shift_q <= vs_shift_d;
      sync_pos_q <= sync_pos_d;
      cs_q       <= ns;
      request_q  <= request_d;
      bust_end_q <= bust_end_d;
      app_en_q   <= app_en_d;
      wren_q     <= wren_d;
      cmd_cnt_q  <= cmd_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
      addr_q     <= addr_d;
    end
  end

  assign o_fifo_rst     = sync_pos_q;
  assign o_fifo_rd      = dat_acc;
  assign o_request      = request_q;
  assign o_app_en       = app_en_q;
  assign o_app_cmd      = 3'd0;
  assign o_addr         = addr_q;
  assign o_app_wdf_data = i_fifo_data;
  assign o_app_wdf_wren = wren_q;
  assign o_app_wdf_end  = wren_q;
  assign o_app_wdf_mask = '0;
  assign o_bust_end     = bust_end_q;
  assign o_wr_busy      = (cs_q == S_DATA_WR);
  assign o_cs           = cs_q;
  assign o_ns           = ns;

`ifdef FRMBUF_WR_STAT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        underflow_q, underflow_d;

  // Frame statistics: beats written and sticky pop-while-empty flag.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    underflow_d = underflow_q;
    if (sync_pos_q) begin
      beat_cnt_d  = '0;
      underflow_d = 1'b0;
    end else begin
      if (dat_acc) begin
        beat_cnt_d = beat_cnt_q + 32'd1;
      end
      if (dat_acc && i_fifo_empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_beat_cnt  = beat_cnt_q;
  assign o_underflow = underflow_q;
`else
  logic unused_fifo_empty;
  assign unused_fifo_empty = i_fifo_empty;
`endif

endmodule

// File: tb/tb_frmbuf_wr.sv
// tb_frmbuf_wr: randomized self-checking bench for frmbuf_wr.
// A word-array FIFO feeds the writer; a reference model predicts the data
// order, command addresses, burst counts and latencies from the block rules.
module tb_frmbuf_wr;

  localparam int P_WR_NUM   = 32;
  localparam int P_ADDR_ADD = 8;
  localparam int P_DATA_W   = 256;
  localparam int MAX_CYC    = 600;

  logic                  i_ddr3_clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_system_init;
  logic                  i_src_vsync;
  logic                  o_fifo_rst;
  logic [9:0]            i_fifo_rd_cnt;
  logic                  i_fifo_empty;
  logic [P_DATA_W-1:0]   i_fifo_data;
  logic                  o_fifo_rd;
  logic                  o_request;
  logic                  i_response;
  logic                  o_app_en;
  logic [2:0]            o_app_cmd;
  logic [26:0]           o_addr;
  logic                  i_app_rdy;
  logic [P_DATA_W-1:0]   o_app_wdf_data;
  logic                  o_app_wdf_wren;
  logic                  o_app_wdf_end;
  logic [P_DATA_W/8-1:0] o_app_wdf_mask;
  logic                  i_app_wdf_rdy;
  logic [26:0]           i_addr_inital;
  logic                  o_bust_end;
  logic                  o_wr_busy;
  logic [2:0]            o_cs;
  logic [2:0]            o_ns;
`ifdef FRMBUF_WR_STAT_EN
  logic [31:0]           o_beat_cnt;
  logic                  o_underflow;
`endif

  frmbuf_wr #(
    .P_WR_NUM   (P_WR_NUM),
    .P_ADDR_ADD (P_ADDR_ADD),
    .P_DATA_W   (P_DATA_W)
  ) dut (
    .i_ddr3_clk     (i_ddr3_clk),
    .i_rst_n        (i_rst_n),
    .i_system_init  (i_system_init),
    .i_src_vsync    (i_src_vsync),
    .o_fifo_rst     (o_fifo_rst),
    .i_fifo_rd_cnt  (i_fifo_rd_cnt),
    .i_fifo_empty   (i_fifo_empty),
    .i_fifo_data    (i_fifo_data),
    .o_fifo_rd      (o_fifo_rd),
    .o_request      (o_request),
    .i_response     (i_response),
    .o_app_en       (o_app_en),
    .o_app_cmd      (o_app_cmd),
    .o_addr         (o_addr),
    .i_app_rdy      (i_app_rdy),
    .o_app_wdf_data (o_app_wdf_data),
    .o_app_wdf_wren (o_app_wdf_wren),
    .o_app_wdf_end  (o_app_wdf_end),
    .o_app_wdf_mask (o_app_wdf_mask),
    .i_app_wdf_rdy  (i_app_wdf_rdy),
    .i_addr_inital  (i_addr_inital),
    .o_bust_end     (o_bust_end),
    .o_wr_busy      (o_wr_busy),
`ifdef FRMBUF_WR_STAT_EN
    .o_beat_cnt     (o_beat_cnt),
    .o_underflow    (o_underflow),
`endif
    .o_cs           (o_cs),
    .o_ns           (o_ns)
  );

  always #5 i_ddr3_clk = ~i_ddr3_clk;

  // Source FIFO: fixed random word array, FWFT head, pointer reset on flush.
  logic [P_DATA_W-1:0] fifo_mem [0:255];
  logic [7:0]          rd_ptr;
  assign i_fifo_data = fifo_mem[rd_ptr];

  // Pop the head word on each read; a flush restarts the frame's stream.
  always @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_ptr <= '0;
    else if (o_fifo_rst) rd_ptr <= '0;
    else if (o_fifo_rd) rd_ptr <= rd_ptr + 8'd1;
  end

  int          check_count = 0;
  int          fail_count  = 0;
  logic [26:0] exp_addr;
  int          frame_words;
  int          burst_dat, burst_cmd, bust_seen, sync_seen;
  int          first_dat_edge, first_cmd_edge, bust_edge;
  int          cyc, stall_cnt;
  logic        prev_en_wait, prev_wren_wait, stall_done;

  task automatic checkOutput(input string tag, input logic [P_DATA_W-1:0] actual,
                             input logic [P_DATA_W-1:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int mode);
    case (mode)
      1: begin
        i_app_wdf_rdy = 1'b1;
        i_app_rdy     = 1'b1;
        if (!stall_done && burst_cmd == 10) begin
          if (stall_cnt < 30) begin
            i_app_rdy = 1'b0;
            stall_cnt++;
          end else begin
            checkOutput("stall_data_first", 256'(burst_dat), 256'(P_WR_NUM));
            checkOutput("stall_cmd_frozen", 256'(burst_cmd), 256'd10);
            checkOutput("stall_en_held", o_app_en, 1'b1);
            stall_done = 1'b1;
          end
        end
      end
      2: begin
        i_app_wdf_rdy = (cyc % 2 == 0);
        i_app_rdy     = 1'($urandom_range(0, 1));
      end
      3: begin
        i_app_wdf_rdy = ($urandom_range(0, 3) != 0);
        i_app_rdy     = ($urandom_range(0, 3) != 0);
      end
      default: begin
        i_app_wdf_rdy = 1'b1;
        i_app_rdy     = 1'b1;
      end
    endcase
  endtask

  task automatic sampleCycle();
    logic dacc, cacc;
    dacc = o_app_wdf_wren && i_app_wdf_rdy;
    cacc = o_app_en && i_app_rdy;
    if (prev_en_wait) checkOutput("app_en_hold", o_app_en, 1'b1);
    if (prev_wren_wait) checkOutput("wdf_wren_hold", o_app_wdf_wren, 1'b1);
    checkOutput("fifo_rd", o_fifo_rd, dacc);
    if (dacc) begin
      checkOutput("wdf_data", o_app_wdf_data, fifo_mem[frame_words[7:0]]);
      checkOutput("wdf_end", o_app_wdf_end, 1'b1);
      if (first_dat_edge < 0) first_dat_edge = cyc + 1;
      frame_words++;
      burst_dat++;
    end
    if (cacc) begin
      checkOutput("cmd_addr", o_addr, exp_addr);
      if (first_cmd_edge < 0) first_cmd_edge = cyc + 1;
      exp_addr = exp_addr + 27'(P_ADDR_ADD);
      burst_cmd++;
    end
    checkOutput("cmd_not_ahead", (burst_cmd <= burst_dat), 1'b1);
    checkOutput("beats_bounded", (burst_dat <= P_WR_NUM), 1'b1);
    if (o_bust_end) begin
      bust_seen++;
      if (bust_edge < 0) bust_edge = cyc + 1;
    end
    prev_en_wait   = o_app_en && !i_app_rdy;
    prev_wren_wait = o_app_wdf_wren && !i_app_wdf_rdy;
    if (o_fifo_rst) begin
      sync_seen++;
      exp_addr       = i_addr_inital;
      frame_words    = 0;
      prev_en_wait   = 1'b0;
      prev_wren_wait = 1'b0;
    end
  endtask

  task automatic doVsync(input logic [26:0] base);
    int w;
    i_addr_inital = base;
    @(negedge i_ddr3_clk);
    i_src_vsync = 1'b0;
    w = 0;
    while (!o_fifo_rst && w < 20) begin
      @(negedge i_ddr3_clk);
      w++;
    end
    checkOutput("vsync_pulse", o_fifo_rst, 1'b1);
    @(negedge i_ddr3_clk);
    checkOutput("vsync_pulse_width", o_fifo_rst, 1'b0);
    checkOutput("vsync_addr_load", o_addr, base);
    checkOutput("vsync_state", o_cs, 3'd0);
    exp_addr    = base;
    frame_words = 0;
    i_src_vsync = 1'b1;
    repeat (12) @(negedge i_ddr3_clk);
  endtask

  // mode 0: rdy high, 1: command stall at beat 10, 2: wdf_rdy toggling,
  // 3: random ready, 4: vsync fall at beat 15 aborting the burst
  task automatic runBurst(input int mode, input int grant_delay);
    int  wait_cyc;
    bit  done;
    burst_dat = 0; burst_cmd = 0; bust_seen = 0; sync_seen = 0;
    first_dat_edge = -1; first_cmd_edge = -1; bust_edge = -1;
    prev_en_wait = 1'b0; prev_wren_wait = 1'b0;
    stall_cnt = 0; stall_done = 1'b0;
    i_app_rdy = 1'b1; i_app_wdf_rdy = 1'b1;
    @(negedge i_ddr3_clk);
    wait_cyc = 0;
    while (!o_request && wait_cyc < 50) begin
      @(negedge i_ddr3_clk);
      wait_cyc++;
    end
    checkOutput("request_seen", o_request, 1'b1);
    if (!o_request) return;
    repeat (grant_delay) @(negedge i_ddr3_clk);
    checkOutput("request_held", o_request, 1'b1);
    i_response = 1'b1;
    @(negedge i_ddr3_clk);
    i_response = 1'b0;
    checkOutput("wr_busy", o_wr_busy, 1'b1);
    checkOutput("request_drop", o_request, 1'b0);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      applyStimulus(mode);
      #1;
      sampleCycle();
      if (mode == 4 && burst_dat >= 15 && i_src_vsync) i_src_vsync = 1'b0;
      if (mode == 4) done = (sync_seen > 0);
      else done = (bust_seen > 0);
      @(negedge i_ddr3_clk);
      cyc++;
    end
    checkOutput("burst_finished", done, 1'b1);
    if (mode == 4) begin
      checkOutput("abort_addr", o_addr, i_addr_inital);
      checkOutput("abort_state", o_cs, 3'd0);
      checkOutput("abort_wren", o_app_wdf_wren, 1'b0);
      checkOutput("abort_en", o_app_en, 1'b0);
      for (int p = 0; p < 6; p++) begin
        applyStimulus(0);
        #1;
        sampleCycle();
        @(negedge i_ddr3_clk);
      end
      checkOutput("abort_no_bust_end", 256'(bust_seen), 256'd0);
      checkOutput("abort_single_rst", 256'(sync_seen), 256'd1);
      i_src_vsync = 1'b1;
    end else begin
      checkOutput("end_state_idle", o_cs, 3'd0);
      checkOutput("end_bust_single", o_bust_end, 1'b0);
      checkOutput("end_wren_low", o_app_wdf_wren, 1'b0);
      checkOutput("end_en_low", o_app_en, 1'b0);
      checkOutput("burst_data_beats", 256'(burst_dat), 256'(P_WR_NUM));
      checkOutput("burst_cmds", 256'(burst_cmd), 256'(P_WR_NUM));
      checkOutput("bust_end_count", 256'(bust_seen), 256'd1);
      checkOutput("end_addr", o_addr, exp_addr);
      if (mode == 0) begin
        checkOutput("lat_first_data", 256'(first_dat_edge), 256'd1);
        checkOutput("lat_first_cmd", 256'(first_cmd_edge), 256'd2);
        checkOutput("lat_bust_end", 256'(bust_edge), 256'(P_WR_NUM + 3));
      end
    end
`ifdef FRMBUF_WR_STAT_EN
    checkOutput("beat_cnt", o_beat_cnt, 256'(frame_words));
`endif
  endtask

  // Watchdog so the run always reaches a summary.
  initial begin
    #500000;
    fail_count++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

  initial begin
    for (int i = 0; i < 256; i++) fifo_mem[i] = {8{$urandom}};
    i_rst_n = 1'b0; i_system_init = 1'b0; i_src_vsync = 1'b0;
    i_fifo_rd_cnt = 10'd0; i_fifo_empty = 1'b0; i_response = 1'b0;
    i_app_rdy = 1'b0; i_app_wdf_rdy = 1'b0; i_addr_inital = 27'h100;
    exp_addr = '0; frame_words = 0; cyc = 0;
    repeat (3) @(negedge i_ddr3_clk);
    checkOutput("rst_addr", o_addr, 27'd0);
    checkOutput("rst_cs", o_cs, 3'd0);
    checkOutput("rst_request", o_request, 1'b0);
    checkOutput("rst_app_en", o_app_en, 1'b0);
    checkOutput("rst_wren", o_app_wdf_wren, 1'b0);
    checkOutput("rst_bust_end", o_bust_end, 1'b0);
    checkOutput("rst_fifo_rst", o_fifo_rst, 1'b0);
    checkOutput("rst_wr_busy", o_wr_busy, 1'b0);
    checkOutput("app_cmd", o_app_cmd, 3'd0);
    checkOutput("wdf_mask", o_app_wdf_mask, 32'd0);
    i_rst_n = 1'b1;
    i_src_vsync = 1'b1;
    repeat (12) @(negedge i_ddr3_clk);
    checkOutput("idle_without_init", o_cs, 3'd0);

    doVsync(27'h100);

    $display("[TB] buffer threshold");
    i_system_init = 1'b1;
    i_fifo_rd_cnt = 10'(P_WR_NUM - 1);
    repeat (6) @(negedge i_ddr3_clk);
    checkOutput("below_threshold_state", o_cs, 3'd1);
    checkOutput("below_threshold_req", o_request, 1'b0);
    i_fifo_rd_cnt = 10'(P_WR_NUM);
    @(negedge i_ddr3_clk);
    checkOutput("threshold_req", o_request, 1'b1);
    i_fifo_rd_cnt = 10'd40;

    $display("[TB] full-rate burst");
    runBurst(0, 3);
    checkOutput("frame_end_addr", o_addr, 27'h200);
    $display("[TB] command stall burst");
    runBurst(1, 1);
    $display("[TB] toggling wdf_rdy burst");
    runBurst(2, 2);
    $display("[TB] random ready bursts");
    for (int b = 0; b < 3; b++) runBurst(3, int'($urandom_range(0, 4)));

    $display("[TB] vsync abort");
    i_addr_inital = 27'($urandom) & 27'h7FFFFF8;
    runBurst(4, 1);
    runBurst(0, 2);
    runBurst(0, 1);
`ifdef FRMBUF_WR_STAT_EN
    checkOutput("beat_cnt_two_bursts", o_beat_cnt, 32'd64);
    checkOutput("underflow_clear", o_underflow, 1'b0);
    i_fifo_empty = 1'b1;
    runBurst(0, 1);
    i_fifo_empty = 1'b0;
    repeat (3) @(negedge i_ddr3_clk);
    checkOutput("underflow_sticky", o_underflow, 1'b1);
    doVsync(27'h40);
    checkOutput("underflow_vsync_clear", o_underflow, 1'b0);
    checkOutput("beat_cnt_vsync_clear", o_beat_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
